// File: rtl/and_chk_pkg.sv
// Shared types and constants for the AND-block built-in self-test: FSM state
// encoding, LFSR seed/taps and the seed-sanitising helper.
package and_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  // An all-zero seed would lock the LFSR, so it is swapped for the default.
  function automatic logic [15:0] eff_seed(input logic [15:0] seed);
    return (seed == 16'h0000) ? DEFAULT_SEED : seed;
  endfunction

endpackage

// File: rtl/and_chk_lfsr16.sv
// 16-bit right-shifting Galois LFSR (x^16+x^14+x^13+x^11+1) with synchronous
// seed load; load has priority over step.
module and_chk_lfsr16
  import and_chk_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= seed;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/and_stim_checker.sv
// LFSR-driven operand generator and result checker for an N-bit AND block.
// Define AND_CHK_CAPTURE_EN to build the first-failure capture registers.
module and_stim_checker
  import and_chk_pkg::*;
#(
  parameter int          N           = 5,
  parameter int          NUM_VECTORS = 16,
  parameter logic [15:0] SEED        = 16'hACE1,
  localparam int         CW          = $clog2(NUM_VECTORS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [N-1:0]  a_o,
  output logic [N-1:0]  b_o,
  input  logic [N-1:0]  out_i,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] vec_cnt,
  output logic [CW-1:0] err_cnt,
  output logic [N-1:0]  fail_a,
  output logic [N-1:0]  fail_b,
  output logic [N-1:0]  fail_out
);

  state_t      state;
  state_t      state_nxt;
  logic        busy_nxt;
  logic        done_nxt;
  logic [15:0] lfsr_q;
  logic        lfsr_unused;

  logic start_ok;
  logic last_vec;
  logic mismatch;

  assign start_ok = start && (state == ST_IDLE || state == ST_DONE);
  assign last_vec = (vec_cnt + CW'(1)) == CW'(NUM_VECTORS);
  assign mismatch = (out_i != (a_o & b_o));

  and_chk_lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (start_ok),
    .seed (eff_seed(SEED)),
    .step (state == ST_LOAD),
    .q    (lfsr_q)
  );

  // Only the low 2N LFSR bits feed the operands.
  assign lfsr_unused = ^lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every variable assigned in an always_comb gets a default first so
  // no path through the block leaves it unassigned (which would be a latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_LOAD;
      ST_LOAD:   state_nxt = ST_SETTLE;
      ST_SETTLE: state_nxt = ST_CHECK;
      ST_CHECK:  state_nxt = last_vec ? ST_DONE : ST_LOAD;
      ST_DONE:   if (start) state_nxt = ST_LOAD;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Status flags are decoded from the next state and registered.
  always_comb begin
    busy_nxt = (state_nxt == ST_LOAD) || (state_nxt == ST_SETTLE) ||
               (state_nxt == ST_CHECK);
    done_nxt = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_o     <= '0;
      b_o     <= '0;
      vec_cnt <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
    end else if (start_ok) begin
      vec_cnt <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
    end else if (state == ST_LOAD) begin
      a_o <= lfsr_q[N-1:0];
      b_o <= lfsr_q[2*N-1:N];
    end else if (state == ST_CHECK) begin
      vec_cnt <= vec_cnt + CW'(1);
      if (mismatch) err_cnt <= err_cnt + CW'(1);
      // pass is only meaningful once done rises, so it is set on the last check.
      if (last_vec) pass <= (err_cnt == '0) && !mismatch;
    end
  end

`ifdef AND_CHK_CAPTURE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_a   <= '0;
      fail_b   <= '0;
      fail_out <= '0;
    end else if (start_ok) begin
      fail_a   <= '0;
      fail_b   <= '0;
      fail_out <= '0;
    end else if (state == ST_CHECK && mismatch && err_cnt == '0) begin
      fail_a   <= a_o;
      fail_b   <= b_o;
      fail_out <= out_i;
    end
  end
`else
  assign fail_a   = '0;
  assign fail_b   = '0;
  assign fail_out = '0;
`endif

endmodule
